// File: rtl/swap_ctrl.sv
// swap_ctrl: exchanges two register-file entries and arbitrates the rf ports with a host port.
// Optional completed-swap counter port swap_count when SWAP_CNT_EN is defined.
module swap_ctrl #(
  parameter int N = 8,
  parameter int BITS = 32
`ifdef SWAP_CNT_EN
  , parameter int CNT_W = 16
`endif
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [N-1:0]    addr_a,
  input  logic [N-1:0]    addr_b,
  output logic            busy,
  output logic            done,
  output logic            host_ready,
  input  logic            host_we,
  input  logic [N-1:0]    host_addr_w,
  input  logic [BITS-1:0] host_data_w,
  input  logic [N-1:0]    host_addr_r,
  output logic [BITS-1:0] host_data_r,
  output logic            rf_we,
  output logic [N-1:0]    rf_address_w,
  output logic [BITS-1:0] rf_data_w,
  output logic [N-1:0]    rf_address_r,
  input  logic [BITS-1:0] rf_data_r
`ifdef SWAP_CNT_EN
  , output logic [CNT_W-1:0] swap_count
`endif
);
  localparam logic [1:0] IDLE = 2'd0, RD_A = 2'd1, WR_A = 2'd2, WR_B = 2'd3;
  logic [1:0] state;
  logic [N-1:0] a_q, b_q;
  logic [BITS-1:0] tmp;
  logic idle;
  assign idle = state == IDLE;
  assign busy = !idle;
  assign host_ready = idle;
  assign host_data_r = rf_data_r;
  // WR_B wraps to IDLE through the +1, so the sequence needs no explicit case
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      done <= 1'b0;
    end else begin
      state <= idle ? (start ? RD_A : IDLE) : state + 2'd1;
      done <= state == WR_B;
    end
  end
  always_ff @(posedge clk) begin
    if (idle && start) begin
      a_q <= addr_a;
      b_q <= addr_b;
    end
    if (state == RD_A) tmp <= rf_data_r;
  end
  // engine writes are suppressed under rst so an aborted swap touches the file no further
  always_comb begin
    rf_we = idle ? host_we : (state[1] && !rst);
    rf_address_w = idle ? host_addr_w : (state == WR_B ? b_q : a_q);
    rf_data_w = idle ? host_data_w : (state == WR_B ? tmp : rf_data_r);
    rf_address_r = idle ? host_addr_r : (state == WR_A ? b_q : a_q);
  end
`ifdef SWAP_CNT_EN
  always_ff @(posedge clk) begin
    if (rst) swap_count <= '0;
    else if (state == WR_B) swap_count <= swap_count + 1'b1;
  end
`endif
endmodule

// File: tb/tb_swap_ctrl.sv
// tb_swap_ctrl: directed bench for swap_ctrl with a behavioural register file and a readback scoreboard.
module tb_swap_ctrl;
  logic clk = 1'b0, rst, start, host_we;
  logic [7:0] addr_a, addr_b, host_addr_w, host_addr_r, rf_address_w, rf_address_r;
  logic [31:0] host_data_w, host_data_r, rf_data_w, rf_data_r;
  logic busy, done, host_ready, rf_we;
`ifdef SWAP_CNT_EN
  logic [15:0] swap_count;
`endif
  logic [31:0] mem [256];
  typedef struct packed {logic [7:0] a; logic [31:0] d;} ent_t;
  ent_t sb[$];
  int cnt = 0, errs = 0, exp_cnt = 0;

  swap_ctrl dut (
    .clk(clk), .rst(rst), .start(start), .addr_a(addr_a), .addr_b(addr_b),
    .busy(busy), .done(done), .host_ready(host_ready),
    .host_we(host_we), .host_addr_w(host_addr_w), .host_data_w(host_data_w),
    .host_addr_r(host_addr_r), .host_data_r(host_data_r),
    .rf_we(rf_we), .rf_address_w(rf_address_w), .rf_data_w(rf_data_w),
    .rf_address_r(rf_address_r), .rf_data_r(rf_data_r)
`ifdef SWAP_CNT_EN
    , .swap_count(swap_count)
`endif
  );

  always #5 clk = ~clk;
  assign rf_data_r = mem[rf_address_r];
  always @(posedge clk) if (rf_we) mem[rf_address_w] <= rf_data_w;

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    cnt++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_cnt(input string tag);
`ifdef SWAP_CNT_EN
    chk(tag, 32'(swap_count), 32'(exp_cnt));
`endif
  endtask

  task automatic hw(input logic [7:0] a, input logic [31:0] d);
    host_we = 1'b1;
    host_addr_w = a;
    host_data_w = d;
    step();
    host_we = 1'b0;
  endtask

  task automatic kick(input logic [7:0] a, input logic [7:0] b);
    addr_a = a;
    addr_b = b;
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  // checks cycles 1..4 of a single swap; returns positioned in the done cycle
  task automatic swap_cycles(input string tag);
    for (int i = 1; i <= 3; i++) begin
      chk({tag, "_busy"}, 32'(busy), 32'd1);
      chk({tag, "_ready"}, 32'(host_ready), 32'd0);
      chk({tag, "_done_early"}, 32'(done), 32'd0);
      step();
    end
    chk({tag, "_idle"}, 32'(busy), 32'd0);
    chk({tag, "_done"}, 32'(done), 32'd1);
    exp_cnt++;
  endtask

  task automatic push(input logic [7:0] a, input logic [31:0] d);
    sb.push_back('{a: a, d: d});
  endtask

  task automatic drain(input string tag);
    ent_t e;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      host_addr_r = e.a;
      #1;
      chk($sformatf("%s_rf%0d", tag, e.a), host_data_r, e.d);
    end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = '0;
    rst = 1'b1; start = 1'b0; host_we = 1'b0;
    addr_a = '0; addr_b = '0; host_addr_w = '0; host_data_w = '0; host_addr_r = '0;
    step();
    step();
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_ready", 32'(host_ready), 32'd1);
    chk_cnt("rst_cnt");
    rst = 1'b0;
    // basic swap
    hw(8'd3, 32'hAAAA0001);
    hw(8'd7, 32'h55550002);
    kick(8'd3, 8'd7);
    swap_cycles("t1");
    step();
    chk("t1_done_pulse", 32'(done), 32'd0);
    push(8'd3, 32'h55550002);
    push(8'd7, 32'hAAAA0001);
    drain("t1");
    chk_cnt("t1_cnt");
    // identical addresses
    hw(8'd10, 32'h00001234);
    kick(8'd10, 8'd10);
    swap_cycles("t2");
    step();
    push(8'd10, 32'h00001234);
    drain("t2");
    chk_cnt("t2_cnt");
    // host write held across a swap lands only at the done-cycle edge
    kick(8'd3, 8'd7);
    host_we = 1'b1;
    host_addr_w = 8'd3;
    host_data_w = 32'hDEAD0000;
    swap_cycles("t3");
    chk("t3_no_host_write", mem[3], 32'hAAAA0001);
    step();
    host_we = 1'b0;
    push(8'd3, 32'hDEAD0000);
    push(8'd7, 32'h55550002);
    drain("t3");
    // host write and start in the same cycle: swap sees the new value
    host_we = 1'b1;
    host_addr_w = 8'd3;
    host_data_w = 32'h0BAD0BAD;
    kick(8'd3, 8'd7);
    host_we = 1'b0;
    swap_cycles("t4");
    step();
    push(8'd7, 32'h0BAD0BAD);
    push(8'd3, 32'h55550002);
    drain("t4");
    chk_cnt("t4_cnt");
    // start held: back-to-back swaps every 4 cycles
    addr_a = 8'd3;
    addr_b = 8'd7;
    start = 1'b1;
    step();
    for (int i = 1; i <= 8; i++) begin
      chk($sformatf("t5_done_c%0d", i), 32'(done), 32'(i == 4 || i == 8));
      chk($sformatf("t5_busy_c%0d", i), 32'(busy), 32'(!(i == 4 || i == 8)));
      if (i == 5) chk("t5_mid_a", mem[3], 32'h0BAD0BAD);
      if (i == 7) start = 1'b0;
      step();
    end
    exp_cnt += 2;
    chk("t5_end_busy", 32'(busy), 32'd0);
    push(8'd3, 32'h55550002);
    push(8'd7, 32'h0BAD0BAD);
    drain("t5");
    chk_cnt("t5_cnt");
    // reset during WR_A aborts the swap with no WR_B write
    kick(8'd3, 8'd7);
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("t6_busy", 32'(busy), 32'd0);
    chk("t6_done", 32'(done), 32'd0);
    chk("t6_ready", 32'(host_ready), 32'd1);
    step();
    chk("t6_stay_idle", 32'(busy), 32'd0);
    chk("t6_no_done", 32'(done), 32'd0);
    exp_cnt = 0;
    chk_cnt("t6_cnt");
    push(8'd7, 32'h0BAD0BAD);
    drain("t6");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cnt, errs);
    $finish;
  end
endmodule
